// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Two-requester arbiter and access sequencer for a 16x8 register file.
// Requester A (control unit) and requester B (debug/loader port) issue
// read/write commands. Grants are round-robin. Each accepted command runs
// IDLE -> XFER -> RESP -> IDLE, which is 3 cycles from acceptance to the
// return to IDLE. A bitmap records which registers have been written, so a
// read of a register that was never written returns 0 with an error flag.
//
// Optional feature macro: REGFILE_ARB_SCRUB_EN
//   When defined, the block leaves reset through a SCRUB state. SCRUB writes
//   0 to every register, one register per cycle, and then sets the whole
//   bitmap before entering IDLE. When undefined, reset goes straight to IDLE
//   with an empty bitmap.
//
// Ports
//   clk                 system clock; all state changes on the rising edge
//   reset               synchronous, active-low reset
//   a_valid/b_valid     command valid
//   a_write/b_write     1 = write, 0 = read
//   a_addr/b_addr       register number
//   a_wdata/b_wdata     write data
//   a_ready/b_ready     command accepted this cycle (combinational, IDLE only)
//   a_resp_valid/b_...  one-cycle response pulse
//   a_resp_err/b_...    read hit an undefined register (with resp_valid)
//   resp_rdata          shared read data / echoed write data
//   rf_load, rf_dump    register file LoadReg / DumpReg
//   rf_regnum           register file RegNumber (holds outside XFER)
//   rf_wdata            register file data input
//   rf_rdata            register file dumped output
//   busy                high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_resp_valid,
  output logic              a_resp_err,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_resp_valid,
  output logic              b_resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              rf_load,
  output logic              rf_dump,
  output logic [ADDR_W-1:0] rf_regnum,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  localparam int NUM_REGS = 2**ADDR_W;
`ifdef REGFILE_ARB_SCRUB_EN
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
`endif

  typedef enum logic [1:0] {IDLE, XFER, RESP, SCRUB} state_t;

  state_t              state_reg, state_next;
  logic                rr_last_b_reg;   // 1: B was granted last, so A wins a tie
  logic                owner_b_reg;     // requester that owns the command in flight
  logic                cmd_write_reg;
  logic [NUM_REGS-1:0] defined_reg;
  logic [DATA_W-1:0]   resp_rdata_reg;
  logic                resp_err_reg;
  // The command's address and data are latched straight into the register
  // file drive registers, so they are valid throughout XFER and hold after.
  // In SCRUB the address register doubles as the scrub counter.
  logic [ADDR_W-1:0]   rf_regnum_reg;
  logic [DATA_W-1:0]   rf_wdata_reg;
  logic                grant_a, grant_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef REGFILE_ARB_SCRUB_EN
      state_reg      <= SCRUB;
`else
      state_reg      <= IDLE;
`endif
      rr_last_b_reg  <= 1'b1;
      owner_b_reg    <= 1'b0;
      cmd_write_reg  <= 1'b0;
      defined_reg    <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      rf_regnum_reg  <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_a || grant_b) begin
            owner_b_reg   <= grant_b;
            rr_last_b_reg <= grant_b;
            cmd_write_reg <= grant_b ? b_write : a_write;
            rf_regnum_reg <= grant_b ? b_addr  : a_addr;
            rf_wdata_reg  <= grant_b ? b_wdata : a_wdata;
          end
        end
        XFER: begin
          if (cmd_write_reg) begin
            defined_reg[rf_regnum_reg] <= 1'b1;
            resp_rdata_reg             <= rf_wdata_reg;
            resp_err_reg               <= 1'b0;
          end else if (defined_reg[rf_regnum_reg]) begin
            resp_rdata_reg <= rf_rdata;
            resp_err_reg   <= 1'b0;
          end else begin
            // Never-written register: its contents are undriven, so report
            // a clean 0 and flag the error instead of passing them on.
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b1;
          end
        end
`ifdef REGFILE_ARB_SCRUB_EN
        SCRUB: begin
          // Stop on the last register so rf_regnum holds it afterwards.
          if (rf_regnum_reg == LAST_REG) begin
            defined_reg <= '1;
          end else begin
            rf_regnum_reg <= rf_regnum_reg + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    rf_load      = 1'b0;
    rf_dump      = 1'b0;
    a_resp_valid = 1'b0;
    b_resp_valid = 1'b0;
    a_resp_err   = 1'b0;
    b_resp_err   = 1'b0;
    busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        grant_a = a_valid && (!b_valid || rr_last_b_reg);
        grant_b = b_valid && (!a_valid || !rr_last_b_reg);
        a_ready = grant_a;
        b_ready = grant_b;
        if (grant_a || grant_b) state_next = XFER;
      end
      XFER: begin
        rf_load    = cmd_write_reg;
        rf_dump    = !cmd_write_reg;
        state_next = RESP;
      end
      RESP: begin
        a_resp_valid = !owner_b_reg;
        b_resp_valid = owner_b_reg;
        a_resp_err   = !owner_b_reg && resp_err_reg;
        b_resp_err   = owner_b_reg && resp_err_reg;
        state_next   = IDLE;
      end
`ifdef REGFILE_ARB_SCRUB_EN
      SCRUB: begin
        // The reset state is SCRUB; keep the outputs quiet while reset is
        // still held so the scrub only drives the register file once released.
        rf_load = reset;
        busy    = reset;
        if (rf_regnum_reg == LAST_REG) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign resp_rdata = resp_rdata_reg;
  assign rf_regnum  = rf_regnum_reg;
  assign rf_wdata   = rf_wdata_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Directed test bench for regfile_arbiter. It includes a behavioural 16x8
// register file model. Inputs change on the falling clock edge, and outputs
// are sampled on the falling edge or #1 after it.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_write, b_valid, b_write;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ready, a_resp_valid, a_resp_err;
  logic       b_ready, b_resp_valid, b_resp_err;
  logic [7:0] resp_rdata;
  logic       rf_load, rf_dump;
  logic [3:0] rf_regnum;
  logic [7:0] rf_wdata, rf_rdata;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Register file model. Never-written entries read back a recognisable junk
  // value, so any leak of undefined contents is visible.
  logic [7:0] rf_mem [16];
  initial for (int i = 0; i < 16; i++) rf_mem[i] = 8'hEE;
  always @(posedge clk) if (rf_load) rf_mem[rf_regnum] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_regnum];

  regfile_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_resp_valid(a_resp_valid), .a_resp_err(a_resp_err),
    .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_resp_valid(b_resp_valid), .b_resp_err(b_resp_err),
    .resp_rdata(resp_rdata),
    .rf_load(rf_load), .rf_dump(rf_dump), .rf_regnum(rf_regnum),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // This task drives one command and waits a bounded time for it to be
  // accepted. It then reports what the bus showed up to the response: the
  // response latency counted from the accept edge, plus the rf strobes.
  task automatic run_cmd(input bit use_b, input bit wr, input logic [3:0] addr,
                         input logic [7:0] data, output bit acc, output int lat,
                         output bit err, output logic [7:0] rdata, output int loads,
                         output int dumps, output logic [3:0] seen_reg,
                         output logic [7:0] seen_wdata);
    acc = 0; lat = 0; err = 0; rdata = '0; loads = 0; dumps = 0;
    seen_reg = '0; seen_wdata = '0;
    @(negedge clk);
    if (use_b) begin b_valid = 1; b_write = wr; b_addr = addr; b_wdata = data; end
    else       begin a_valid = 1; a_write = wr; a_addr = addr; a_wdata = data; end
    for (int i = 0; i < 8 && !acc; i++) begin
      #1;
      if (use_b ? b_ready : a_ready) acc = 1;
      else @(negedge clk);
    end
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    if (!acc) return;
    for (int i = 1; i <= 6; i++) begin
      if (rf_load) begin loads++; seen_reg = rf_regnum; seen_wdata = rf_wdata; end
      if (rf_dump) begin dumps++; seen_reg = rf_regnum; end
      if (use_b ? b_resp_valid : a_resp_valid) begin
        lat = i; err = use_b ? b_resp_err : a_resp_err; rdata = resp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 0; a_valid = 0; b_valid = 0; a_write = 0; b_write = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if ({rf_load, rf_dump} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b want 00", {rf_load, rf_dump}); end
    vectors++; if ({a_ready, b_ready, a_resp_valid, b_resp_valid, a_resp_err, b_resp_err} !== 6'b0) begin
      miscompares++; $display("FAIL reset_handshake: got %b want 000000", {a_ready, b_ready, a_resp_valid, b_resp_valid, a_resp_err, b_resp_err}); end
    vectors++; if ({rf_regnum, rf_wdata, resp_rdata} !== 20'h0) begin
      miscompares++; $display("FAIL reset_data: got regnum=%h wdata=%h rdata=%h want 0/00/00", rf_regnum, rf_wdata, resp_rdata); end
    reset = 1;
  endtask

`ifdef REGFILE_ARB_SCRUB_EN
  task automatic test_scrub();
    bit acc; int lat, loads, dumps; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    a_valid = 1; a_write = 0; a_addr = 4'd15;
    for (int i = 0; i < 16; i++) begin
      #1;
      vectors++;
      if (!(rf_load === 1'b1 && rf_regnum === 4'(i) && rf_wdata === 8'h00 && a_ready === 1'b0 && busy === 1'b1)) begin
        miscompares++;
        $display("FAIL scrub_cycle%0d: got load=%b reg=%h data=%h ready=%b busy=%b want 1/%h/00/0/1",
                 i, rf_load, rf_regnum, rf_wdata, a_ready, busy, 4'(i));
      end
      @(negedge clk);
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL scrub_done_busy: got %b want 0", busy); end
    a_valid = 0;
    run_cmd(0, 0, 4'd15, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, lat[3:0], err, rd} !== {1'b1, 4'd2, 1'b0, 8'h00}) begin
      miscompares++; $display("FAIL scrub_read_r15: got acc=%b lat=%0d err=%b data=%h want 1/2/0/00", acc, lat, err, rd); end
  endtask
`endif

  task automatic test_write_read();
    bit acc; int lat, loads, dumps; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    run_cmd(0, 1, 4'd3, 8'h5A, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if (!(acc && lat == 2)) begin miscompares++; $display("FAIL wr_latency: got acc=%b lat=%0d want 1/2", acc, lat); end
    vectors++; if (!(loads == 1 && dumps == 0 && sr === 4'd3 && sw === 8'h5A)) begin
      miscompares++; $display("FAIL wr_bus: got loads=%0d dumps=%0d reg=%h data=%h want 1/0/3/5a", loads, dumps, sr, sw); end
    vectors++; if ({err, rd} !== {1'b0, 8'h5A}) begin miscompares++; $display("FAIL wr_resp: got err=%b data=%h want 0/5a", err, rd); end
    run_cmd(0, 0, 4'd3, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if (!(acc && lat == 2 && loads == 0 && dumps == 1 && sr === 4'd3)) begin
      miscompares++; $display("FAIL rd_bus: got acc=%b lat=%0d loads=%0d dumps=%0d reg=%h want 1/2/0/1/3", acc, lat, loads, dumps, sr); end
    vectors++; if ({err, rd} !== {1'b0, 8'h5A}) begin miscompares++; $display("FAIL rd_r3: got err=%b data=%h want 0/5a", err, rd); end
  endtask

  task automatic test_undefined_read();
    bit acc; int lat, loads, dumps; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    run_cmd(1, 0, 4'd7, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if (!(acc && lat == 2)) begin miscompares++; $display("FAIL undef_b_resp: got acc=%b lat=%0d want 1/2", acc, lat); end
    vectors++; if ({err, rd} !== {1'b1, 8'h00}) begin miscompares++; $display("FAIL undef_r7: got err=%b data=%h want 1/00", err, rd); end
  endtask

  task automatic test_alternation();
    bit acc; int lat, loads, dumps; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    int who[4], at[4], n, overlap, both;
    n = 0; overlap = 0; both = 0;
    @(negedge clk);
    a_valid = 1; a_write = 1; a_addr = 4'd1; a_wdata = 8'h10;
    b_valid = 1; b_write = 1; b_addr = 4'd2; b_wdata = 8'h20;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      #1;
      if (rf_load && rf_dump) overlap++;
      if (a_ready && b_ready) both++;
      if (a_ready || b_ready) begin who[n] = b_ready ? 1 : 0; at[n] = cyc; n++; end
      @(negedge clk);
    end
    a_valid = 0; b_valid = 0;
    repeat (3) @(negedge clk);
    vectors++; if (n != 4) begin miscompares++; $display("FAIL alt_grants: got %0d want 4", n); end
    else begin
      vectors++; if ({who[0][0], who[1][0], who[2][0], who[3][0]} !== 4'b0101) begin
        miscompares++; $display("FAIL alt_order: got %0d%0d%0d%0d want 0101 (0=A)", who[0], who[1], who[2], who[3]); end
      vectors++; if (!(at[0] == 0 && at[1] == 3 && at[2] == 6 && at[3] == 9)) begin
        miscompares++; $display("FAIL alt_spacing: got %0d,%0d,%0d,%0d want 0,3,6,9", at[0], at[1], at[2], at[3]); end
    end
    vectors++; if (overlap != 0 || both != 0) begin
      miscompares++; $display("FAIL alt_exclusive: got load&dump=%0d both_ready=%0d want 0/0", overlap, both); end
    run_cmd(0, 0, 4'd1, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, err, rd} !== {1'b1, 1'b0, 8'h10}) begin miscompares++; $display("FAIL alt_r1: got acc=%b err=%b data=%h want 1/0/10", acc, err, rd); end
    run_cmd(1, 0, 4'd2, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, err, rd} !== {1'b1, 1'b0, 8'h20}) begin miscompares++; $display("FAIL alt_r2: got acc=%b err=%b data=%h want 1/0/20", acc, err, rd); end
  endtask

  task automatic test_same_addr();
    bit acc; int lat, loads, dumps; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    int a_at, b_at, ra, rb;
    a_at = -1; b_at = -1; ra = -1; rb = -1;
    @(negedge clk);
    a_valid = 1; a_write = 1; a_addr = 4'd4; a_wdata = 8'h11;
    b_valid = 1; b_write = 1; b_addr = 4'd4; b_wdata = 8'h22;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (a_ready) a_at = cyc;
      if (b_ready) b_at = cyc;
      if (a_resp_valid) ra = cyc;
      if (b_resp_valid) rb = cyc;
      @(negedge clk);
      if (a_at >= 0) a_valid = 0;
      if (b_at >= 0) b_valid = 0;
    end
    a_valid = 0; b_valid = 0;
    vectors++; if (!(a_at == 0 && b_at == 3 && ra == 2 && rb == 5)) begin
      miscompares++; $display("FAIL same_order: got a_acc=%0d b_acc=%0d a_resp=%0d b_resp=%0d want 0/3/2/5", a_at, b_at, ra, rb); end
    run_cmd(0, 0, 4'd4, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, err, rd} !== {1'b1, 1'b0, 8'h22}) begin miscompares++; $display("FAIL same_r4: got acc=%b err=%b data=%h want 1/0/22", acc, err, rd); end
  endtask

  task automatic test_reset_abort();
    bit acc; int lat, loads, dumps, stray; bit err; logic [7:0] rd, sw; logic [3:0] sr;
    acc = 0; stray = 0;
    @(negedge clk);
    a_valid = 1; a_write = 1; a_addr = 4'd9; a_wdata = 8'h77;
    for (int i = 0; i < 8 && !acc; i++) begin
      #1;
      if (a_ready) acc = 1; else @(negedge clk);
    end
    @(negedge clk);
    a_valid = 0;
    vectors++; if ({acc, rf_load} !== 2'b11) begin miscompares++; $display("FAIL abort_xfer: got acc=%b load=%b want 1/1", acc, rf_load); end
    reset = 0;
    @(negedge clk);
    vectors++; if ({busy, rf_load, a_resp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL abort_state: got busy=%b load=%b resp=%b want 0/0/0", busy, rf_load, a_resp_valid); end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_resp_valid || b_resp_valid) stray++;
    end
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL abort_no_resp: got %0d responses want 0", stray); end
    run_cmd(0, 0, 4'd9, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, err, rd} !== {1'b1, 1'b1, 8'h00}) begin miscompares++; $display("FAIL abort_r9: got acc=%b err=%b data=%h want 1/1/00", acc, err, rd); end
    run_cmd(1, 0, 4'd3, 8'h00, acc, lat, err, rd, loads, dumps, sr, sw);
    vectors++; if ({acc, err, rd} !== {1'b1, 1'b1, 8'h00}) begin miscompares++; $display("FAIL abort_bitmap_r3: got acc=%b err=%b data=%h want 1/1/00", acc, err, rd); end
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_ARB_SCRUB_EN
    test_scrub();
`else
    test_write_read();
    test_undefined_read();
    test_alternation();
    test_same_addr();
    test_reset_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
